// File: rtl/hnf_data_buf_ctl_pkg.sv
// hnf_data_buf_ctl_pkg: op encodings and width helper shared by the HNF data-buffer controller
package hnf_data_buf_ctl_pkg;
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hnf_dbuf_wq.sv
// hnf_dbuf_wq: write-queue FIFO of {idx,lane,data} entries with a per-entry index match vector
// Ports: push/push_* enqueue (ignored when full), pop dequeues head (ignored when empty),
// head_* current oldest entry, full/empty from registered count, match[i]=entry i valid and idx==cmp_idx.
module hnf_dbuf_wq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int LANE_W = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_idx,
  input  logic [LANE_W-1:0] push_lane,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_idx,
  output logic [LANE_W-1:0] head_lane,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] cmp_idx,
  output logic [DEPTH-1:0]  match
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [ADDR_W-1:0] ent_idx_q [DEPTH];
  logic [LANE_W-1:0] ent_lane_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (PTR_W+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head_idx = ent_idx_q[rd_ptr_q];
  assign head_lane = ent_lane_q[rd_ptr_q];
  assign head_data = ent_data_q[rd_ptr_q];
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_idx_q[wr_ptr_q] <= push_idx;
      ent_lane_q[wr_ptr_q] <= push_lane;
      ent_data_q[wr_ptr_q] <= push_data;
    end
  end
  // An entry is live when its distance past the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_m
    logic [PTR_W-1:0] rel;
    assign rel = PTR_W'(i) - rd_ptr_q;
    assign match[i] = ({1'b0, rel} < cnt_q) && (ent_idx_q[i] == cmp_idx);
  end
endmodule

// File: rtl/hnf_data_buf_ctl.sv
// hnf_data_buf_ctl: front-end controller for the HNF masked single-port data-buffer SRAM
// Ports: wr_* beat write requests (queued), rd_* full-line reads (granted directly), rsp_* tagged read data,
// ram_* registered SRAM drive, ram_rdata SRAM output, wq_empty drain indicator.
// Option: define HNF_DBUF_RAW_HAZARD_EN to hold reads that hit a queued or in-flight write to the same index.
module hnf_data_buf_ctl
  import hnf_data_buf_ctl_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 256,
  parameter int LANES      = 2,
  parameter int WQ_DEPTH   = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3,
  localparam int LANE_W    = width_of(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_idx,
  input  logic [LANE_W-1:0]       wr_lane,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_W-1:0]       rd_idx,
  output logic                    rsp_valid,
  output logic [ADDR_W-1:0]       rsp_idx,
  output logic [DATA_W*LANES-1:0] rsp_data,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [LANES-1:0]        ram_wmask,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W*LANES-1:0] ram_rdata,
  output logic                    wq_empty
);
  localparam int SW = width_of(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  op_e op;
  logic wq_full, wq_empty_w, hazard, grant_rd;
  logic [ADDR_W-1:0] head_idx;
  logic [LANE_W-1:0] head_lane;
  logic [DATA_W-1:0] head_data;
  logic [WQ_DEPTH-1:0] wq_match;
  logic [SW-1:0] starve_q, starve_d;
  logic ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [LANES-1:0] ram_wmask_q, ram_wmask_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pidx_q, pidx_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [DATA_W*LANES-1:0] rsp_data_q, rsp_data_d;
  hnf_dbuf_wq #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LANE_W(LANE_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_valid),
    .push_idx (wr_idx),
    .push_lane(wr_lane),
    .push_data(wr_data),
    .pop      (op == OP_WRITE),
    .head_idx (head_idx),
    .head_lane(head_lane),
    .head_data(head_data),
    .full     (wq_full),
    .empty    (wq_empty_w),
    .cmp_idx  (rd_idx),
    .match    (wq_match)
  );
`ifdef HNF_DBUF_RAW_HAZARD_EN
  assign hazard = |wq_match | (ram_we_q & (ram_addr_q == rd_idx));
`else
  logic unused_match;
  assign unused_match = ^wq_match;
  assign hazard = 1'b0;
`endif
  // Reads win unless the starvation limit is reached with a write waiting.
  assign grant_rd = rd_valid & ~hazard & (wq_empty_w | (starve_q != SMAX));
  assign op = grant_rd ? OP_READ : wq_empty_w ? OP_IDLE : OP_WRITE;
  assign rd_ready = grant_rd;
  assign wr_ready = ~wq_full;
  assign wq_empty = wq_empty_w;
  always_comb begin
    starve_d = (op == OP_WRITE || wq_empty_w) ? '0 : (op == OP_READ && starve_q != SMAX) ? starve_q + SW'(1) : starve_q;
    ram_we_d = op == OP_WRITE;
    ram_wmask_d = op == OP_WRITE ? LANES'(1) << head_lane : '0;
    ram_addr_d = op == OP_WRITE ? head_idx : op == OP_READ ? rd_idx : ram_addr_q;
    ram_wdata_d = op == OP_WRITE ? head_data : ram_wdata_q;
    pv_d = RD_LAT'({pv_q, op == OP_READ});
    pidx_d = (RD_LAT*ADDR_W)'({pidx_q, rd_idx});
    rsp_valid_d = pv_q[RD_LAT-1];
    rsp_idx_d = pv_q[RD_LAT-1] ? pidx_q[RD_LAT-1] : rsp_idx_q;
    rsp_data_d = pv_q[RD_LAT-1] ? ram_rdata : rsp_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wmask_q <= '0;
      ram_wdata_q <= '0;
      pv_q <= '0;
      pidx_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_data_q <= '0;
    end else begin
      starve_q <= starve_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wmask_q <= ram_wmask_d;
      ram_wdata_q <= ram_wdata_d;
      pv_q <= pv_d;
      pidx_q <= pidx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign ram_we = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_wmask = ram_wmask_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_idx = rsp_idx_q;
  assign rsp_data = rsp_data_q;
endmodule
